array_multiplier_8x8: RTL and testbench
=======================================

Name: array_multiplier_8x8

Overview:
- Unsigned 8x8 -> 16-bit multiplier built as a structural array: AND-gate partial products feed rows of half and full adders, with a final ripple-carry row.
- Registered input and output stages make it a fixed 2-cycle-latency datapath element.
- Used wherever a small, area-predictable, non-DSP multiply is needed.

Parameters:
- None. Operand widths are fixed at 8 bits and the product width at 16 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  qualifies a and b for sampling this cycle
- a  input  8  multiplicand, unsigned
- b  input  8  multiplier, unsigned
- product  output  16  a*b, unsigned, registered
- out_valid  output  1  high for one cycle when product holds a new result

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: on a rising clk edge with rst=1, the following clear to 0:
  - input registers a_q, b_q, v_q;
  - product and out_valid.
- Reset dominates in_valid on the same edge. A reset mid-flight discards any in-progress operand, and no out_valid pulse follows for it.
- Stage 1, edge N:
  - if in_valid=1, a_q<=a and b_q<=b;
  - v_q<=in_valid every edge;
  - a_q/b_q hold their previous values when in_valid=0.
- Array (combinational from a_q, b_q):
  - partial products pp[i][j] = a_q[j] & b_q[i] for i,j in 0..7;
  - row 0 is passed through; rows 1..7 are added by carry-save rows of half/full adders;
  - a final 8-bit ripple-carry adder resolves the top bits;
  - the array is built from explicit half_adder/full_adder cells or equivalent gate-level expressions; the behavioural "*" operator is not used.
- Stage 2, edge N+1:
  - product <= array result, only when v_q=1; otherwise product holds its last value;
  - out_valid <= v_q.
- Latency: exactly 2 clk edges from sampling a/b to product/out_valid.
- Throughput: one new operation per cycle; back-to-back in_valid pulses produce back-to-back out_valid pulses in order.
- Arithmetic: product = a*b exactly, with no overflow. The maximum is 255*255 = 65025 = 16'hFE01, which fits in 16 bits. No rounding, saturation or sign handling.
- Idle inputs: changes on a/b while in_valid=0 never affect product.

Test Plan:
- Basic: reset 2 cycles, then a=3,b=2 with in_valid -> 2 cycles later out_valid=1, product=6.
- Streamed operands, one per cycle: (15,15), (128,2), (0,100), (255,1) -> consecutive out_valid pulses with product = 225, 256, 0, 255 in order.
- Extremes: (255,255) -> 65025 (16'hFE01); (0,0) -> 0; (1,1) -> 1; (170,85) -> 14450. Also a random sweep of at least 1000 pairs checked against a*b.
- Hold: after (12,12)->144, toggle a/b with in_valid=0 for 5 cycles -> product stays 144 and out_valid stays 0.
- Reset mid-operation: apply (200,200) with in_valid, assert rst on the next edge -> product=0, out_valid=0, and no pulse appears later.
- Reset priority: rst=1 and in_valid=1 on the same edge with a=9,b=9 -> operand discarded; out_valid stays 0 for the following 3 cycles.

Source files
------------

// File: rtl/array_multiplier_8x8.sv
// ---------------------------------------------------------------------------
// array_multiplier_8x8
//
// Unsigned 8x8 -> 16-bit multiplier built as a structural array of AND-gate
// partial products, carry-save rows of adder cells and a final ripple-carry
// row. The datapath has registered operands and a registered product, so it
// is a fixed two-cycle-latency element that accepts one operation per cycle.
//
// Ports:
//   clk       in   1   system clock, rising edge
//   rst       in   1   synchronous, active-high reset
//   in_valid  in   1   qualifies a/b for sampling this cycle
//   a         in   8   multiplicand, unsigned
//   b         in   8   multiplier, unsigned
//   product   out  16  a*b, registered
//   out_valid out  1   one-cycle pulse when product holds a new result
// ---------------------------------------------------------------------------
module array_multiplier_8x8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] product,
  output logic        out_valid
);

  // Full-adder sum bit.
  function automatic logic fa_sum(input logic x, input logic y, input logic z);
    return x ^ y ^ z;
  endfunction

  // Full-adder carry bit.
  function automatic logic fa_cry(input logic x, input logic y, input logic z);
    return (x & y) | (z & (x ^ y));
  endfunction

  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic        v_q;
  logic [15:0] arr_s;

  // Stage 1: capture operands when qualified; valid tracks in_valid each edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= 8'd0;
      b_q <= 8'd0;
      v_q <= 1'b0;
    end else begin
      v_q <= in_valid;
      if (in_valid) begin
        a_q <= a;
        b_q <= b;
      end else begin
        a_q <= a_q;
        b_q <= b_q;
      end
    end
  end

  // Combinational multiplier array from the stage-1 operands.
  // Row i holds sum/carry bits at weight i+j. Each cell adds the partial
  // product pp[i][j], the previous row's sum one column to the left, and the
  // previous row's carry from the same column. Row 1 sees all-zero carries,
  // so its cells reduce to half adders. Bit 0 of each row's sum is a final
  // product bit; the leftovers of row 7 go through an 8-bit ripple adder.
  always_comb begin
    logic [7:0][7:0] pp_s;
    logic [7:0][8:0] sum_s;
    logic [7:0][7:0] cry_s;
    logic [7:0]      rc_sum_s;
    logic [8:0]      rc_cry_s;

    pp_s     = '0;
    sum_s    = '0;
    cry_s    = '0;
    rc_sum_s = 8'd0;
    rc_cry_s = 9'd0;
    arr_s    = 16'd0;

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        pp_s[i][j] = a_q[j] & b_q[i];
      end
    end

    // Row 0 passes straight through; sum_s[*][8] stays 0 as the empty column.
    sum_s[0] = {1'b0, pp_s[0]};

    for (int i = 1; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        sum_s[i][j] = fa_sum(pp_s[i][j], sum_s[i-1][j+1], cry_s[i-1][j]);
        cry_s[i][j] = fa_cry(pp_s[i][j], sum_s[i-1][j+1], cry_s[i-1][j]);
      end
    end

    // Final ripple row resolves weights 8..15. Its carry-out is provably 0
    // since 255*255 fits in 16 bits.
    for (int j = 0; j < 8; j++) begin
      rc_sum_s[j]   = fa_sum(sum_s[7][j+1], cry_s[7][j], rc_cry_s[j]);
      rc_cry_s[j+1] = fa_cry(sum_s[7][j+1], cry_s[7][j], rc_cry_s[j]);
    end

    for (int i = 0; i < 8; i++) begin
      arr_s[i] = sum_s[i][0];
    end
    arr_s[15:8] = rc_sum_s;
  end

  // Stage 2: register the array result for valid operations only.
  always_ff @(posedge clk) begin
    if (rst) begin
      product   <= 16'd0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v_q;
      if (v_q) begin
        product <= arr_s;
      end else begin
        product <= product;
      end
    end
  end

endmodule

// File: tb/tb_array_multiplier_8x8.sv
module tb_array_multiplier_8x8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] product;
  logic        out_valid;

  int checks;
  int failures;

  logic [7:0]  sa [0:1023];
  logic [7:0]  sb [0:1023];
  logic [15:0] se [0:1023];

  array_multiplier_8x8 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .product   (product),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Streams n operand pairs back-to-back; each result is due one tick after
  // the next operand is presented.
  task automatic run_stream(input string tag, input int n);
    for (int k = 0; k <= n; k++) begin
      if (k < n) begin
        a = sa[k];
        b = sb[k];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (k >= 1) begin
        chk({tag, "_valid"}, {15'd0, out_valid}, 16'd1);
        chk({tag, "_prod"}, product, se[k-1]);
      end
    end
    tick();
    chk({tag, "_idle_valid"}, {15'd0, out_valid}, 16'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = 8'd0;
    b        = 8'd0;

    // Reset state
    tick();
    tick();
    chk("reset_prod", product, 16'd0);
    chk("reset_valid", {15'd0, out_valid}, 16'd0);
    rst = 1'b0;
    tick();

    // Basic 3*2
    a = 8'd3; b = 8'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("basic_lat1_valid", {15'd0, out_valid}, 16'd0);
    tick();
    chk("basic_valid", {15'd0, out_valid}, 16'd1);
    chk("basic_prod", product, 16'd6);
    tick();
    chk("basic_pulse_end", {15'd0, out_valid}, 16'd0);

    // Streamed operands
    sa[0] = 8'd15;  sb[0] = 8'd15;  se[0] = 16'd225;
    sa[1] = 8'd128; sb[1] = 8'd2;   se[1] = 16'd256;
    sa[2] = 8'd0;   sb[2] = 8'd100; se[2] = 16'd0;
    sa[3] = 8'd255; sb[3] = 8'd1;   se[3] = 16'd255;
    run_stream("stream", 4);

    // Extremes
    sa[0] = 8'd255; sb[0] = 8'd255; se[0] = 16'hFE01;
    sa[1] = 8'd0;   sb[1] = 8'd0;   se[1] = 16'd0;
    sa[2] = 8'd1;   sb[2] = 8'd1;   se[2] = 16'd1;
    sa[3] = 8'd170; sb[3] = 8'd85;  se[3] = 16'd14450;
    sa[4] = 8'd255; sb[4] = 8'd128; se[4] = 16'd32640;
    run_stream("extreme", 5);

    // Random sweep
    for (int k = 0; k < 1000; k++) begin
      sa[k] = 8'($urandom_range(255, 0));
      sb[k] = 8'($urandom_range(255, 0));
      se[k] = 16'(sa[k]) * 16'(sb[k]);
    end
    run_stream("random", 1000);

    // Hold: idle operand changes never reach product
    a = 8'd12; b = 8'd12; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("hold_first_prod", product, 16'd144);
    for (int k = 0; k < 5; k++) begin
      a = 8'($urandom_range(255, 0));
      b = 8'($urandom_range(255, 0));
      tick();
      chk("hold_prod", product, 16'd144);
      chk("hold_valid", {15'd0, out_valid}, 16'd0);
    end
    // A fresh valid op after idle uses the new operands
    a = 8'd7; b = 8'd11; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("after_hold_prod", product, 16'd77);
    tick();

    // Reset mid-operation
    a = 8'd200; b = 8'd200; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_prod", product, 16'd0);
    chk("midrst_valid", {15'd0, out_valid}, 16'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("midrst_no_pulse", {15'd0, out_valid}, 16'd0);
      chk("midrst_prod_hold", product, 16'd0);
    end

    // Load a nonzero product, then reset with in_valid on the same edge
    a = 8'd5; b = 8'd6; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("pre_prio_prod", product, 16'd30);
    tick();
    a = 8'd9; b = 8'd9; in_valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("prio_rst_prod", product, 16'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("prio_no_pulse", {15'd0, out_valid}, 16'd0);
      chk("prio_prod", product, 16'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
